// File: rtl/lcd_timing_pkg.sv
// Shared raster geometry and pixel format for the 480x272 RGB LCD.
// Defaults are overridable per instance through top-level parameters.
package lcd_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 480;
    localparam int unsigned H_SYNC_DEF   = 41;
    localparam int unsigned H_BP_DEF     = 2;
    localparam int unsigned H_FP_DEF     = 2;
    localparam int unsigned V_ACTIVE_DEF = 272;
    localparam int unsigned V_SYNC_DEF   = 10;
    localparam int unsigned V_BP_DEF     = 2;
    localparam int unsigned V_FP_DEF     = 2;

    localparam int unsigned H_TOTAL_DEF =
        H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned V_TOTAL_DEF =
        V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;

    localparam int unsigned H_ACT_START_DEF = H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned H_ACT_END_DEF   = H_ACT_START_DEF + H_ACTIVE_DEF;
    localparam int unsigned V_ACT_START_DEF = V_SYNC_DEF + V_BP_DEF;
    localparam int unsigned V_ACT_END_DEF   = V_ACT_START_DEF + V_ACTIVE_DEF;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam rgb565_t BLACK = '0;

    function automatic int unsigned span_total(
        input int unsigned sync,
        input int unsigned bp,
        input int unsigned act,
        input int unsigned fp
    );
        return sync + bp + act + fp;
    endfunction

endpackage

// File: rtl/lcd_raster_counter.sv
// Horizontal/vertical raster counters and region decode.
// Counters sit at 0,0 whenever enable is low.
module lcd_raster_counter
    import lcd_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned V_FP     = V_FP_DEF
) (
    input  logic       LCD_PCLK,
    input  logic       GLOBAL_RESET,
    input  logic       enable,
    output logic       hs,
    output logic       vs,
    output logic       act,
    output logic       origin,
    output logic       line_start,
    output logic       next_act,
    output logic [8:0] next_line_num
);

    localparam int unsigned H_TOTAL =
        span_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int unsigned V_TOTAL =
        span_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNCE = 10'(H_SYNC);
    localparam logic [8:0] V_SYNCE = 9'(V_SYNC);
    localparam logic [9:0] H_ACT_S = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_ACT_E = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [8:0] V_ACT_S = 9'(V_SYNC + V_BP);
    localparam logic [8:0] V_ACT_E = 9'(V_SYNC + V_BP + V_ACTIVE);

    logic [9:0] h_cnt;
    logic [8:0] v_cnt;
    logic [8:0] v_nxt;
    logic       h_act;
    logic       v_act;

    always_ff @(posedge LCD_PCLK or posedge GLOBAL_RESET) begin
        if (GLOBAL_RESET) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 9'd0 : v_cnt + 9'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign hs     = (h_cnt < H_SYNCE);
    assign vs     = (v_cnt < V_SYNCE);
    assign h_act  = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E);
    assign v_act  = (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
    assign act    = h_act && v_act;
    assign origin = (h_cnt == 10'd0) && (v_cnt == 9'd0);

    // The fetcher gets a whole line of lead: decode the line after this one.
    assign line_start    = (h_cnt == 10'd0);
    assign v_nxt         = (v_cnt == V_LAST) ? 9'd0 : v_cnt + 9'd1;
    assign next_act      = (v_nxt >= V_ACT_S) && (v_nxt < V_ACT_E);
    assign next_line_num = v_nxt - V_ACT_S;

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator and pixel pump: pops the line FIFO
// during active pixels and registers syncs, den and RGB565 together.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned V_FP     = V_FP_DEF
) (
    input  logic        LCD_PCLK,
    input  logic        GLOBAL_RESET,
    input  logic        enable,
    input  logic [15:0] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    output logic        line_req,
    output logic [8:0]  line_num,
    output logic        frame_start,
    output logic [4:0]  lcd_r,
    output logic [5:0]  lcd_g,
    output logic [4:0]  lcd_b,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic        lcd_den,
    output logic        underflow
);

    logic       hs;
    logic       vs;
    logic       act;
    logic       origin;
    logic       line_start;
    logic       next_act;
    logic [8:0] next_line_num;
    rgb565_t    px;

    lcd_raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .H_FP     (H_FP),
        .V_ACTIVE (V_ACTIVE),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .V_FP     (V_FP)
    ) u_cnt (
        .LCD_PCLK      (LCD_PCLK),
        .GLOBAL_RESET  (GLOBAL_RESET),
        .enable        (enable),
        .hs            (hs),
        .vs            (vs),
        .act           (act),
        .origin        (origin),
        .line_start    (line_start),
        .next_act      (next_act),
        .next_line_num (next_line_num)
    );

    assign fifo_rd = enable & act & ~fifo_empty;
    assign px      = fifo_rd ? rgb565_t'(fifo_data) : BLACK;

    always_ff @(posedge LCD_PCLK or posedge GLOBAL_RESET) begin
        if (GLOBAL_RESET) begin
            lcd_r       <= '0;
            lcd_g       <= '0;
            lcd_b       <= '0;
            lcd_hsync   <= 1'b0;
            lcd_vsync   <= 1'b0;
            lcd_den     <= 1'b0;
            frame_start <= 1'b0;
            line_req    <= 1'b0;
            line_num    <= '0;
            underflow   <= 1'b0;
        end else if (!enable) begin
            lcd_r       <= '0;
            lcd_g       <= '0;
            lcd_b       <= '0;
            lcd_hsync   <= 1'b0;
            lcd_vsync   <= 1'b0;
            lcd_den     <= 1'b0;
            frame_start <= 1'b0;
            line_req    <= 1'b0;
            line_num    <= '0;
            underflow   <= 1'b0;
        end else begin
            lcd_r       <= px.r;
            lcd_g       <= px.g;
            lcd_b       <= px.b;
            lcd_hsync   <= hs;
            lcd_vsync   <= vs;
            lcd_den     <= act;
            frame_start <= origin;
            line_req    <= line_start & next_act;
            if (line_start && next_act)
                line_num <= next_line_num;
            // A new frame wins over an underflow seen in the same cycle.
            if (origin)
                underflow <= 1'b0;
            else if (act && fifo_empty)
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench: default 480x272 raster plus a small raster that
// wraps frames, both checked per cycle against an arithmetic model.
module tb_lcd_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic [15:0] data  [2];
    logic        empty [2];
    logic        rd    [2];
    logic        lreq  [2];
    logic [8:0]  lnum  [2];
    logic        fs    [2];
    logic [4:0]  r     [2];
    logic [5:0]  g     [2];
    logic [4:0]  b     [2];
    logic        hsy   [2];
    logic        vsy   [2];
    logic        den   [2];
    logic        uf    [2];

    int HA[2] = '{480, 16};
    int HS[2] = '{41, 4};
    int HB[2] = '{2, 3};
    int HF[2] = '{2, 2};
    int VA[2] = '{272, 6};
    int VS[2] = '{10, 2};
    int VB[2] = '{2, 3};
    int VF[2] = '{2, 2};

    int          pos   [2];
    logic [15:0] ramp  [2];
    bit          m_uf  [2];
    int          m_ln  [2];

    int passes = 0;
    int total  = 0;

    int  c_lr, c_den, c_hs, c_vs;
    bit  full;

    always #50 clk = ~clk;

    lcd_timing_gen u0 (
        .LCD_PCLK(clk), .GLOBAL_RESET(rst), .enable(en),
        .fifo_data(data[0]), .fifo_empty(empty[0]), .fifo_rd(rd[0]),
        .line_req(lreq[0]), .line_num(lnum[0]), .frame_start(fs[0]),
        .lcd_r(r[0]), .lcd_g(g[0]), .lcd_b(b[0]),
        .lcd_hsync(hsy[0]), .lcd_vsync(vsy[0]), .lcd_den(den[0]),
        .underflow(uf[0])
    );

    lcd_timing_gen #(
        .H_ACTIVE(16), .H_SYNC(4), .H_BP(3), .H_FP(2),
        .V_ACTIVE(6), .V_SYNC(2), .V_BP(3), .V_FP(2)
    ) u1 (
        .LCD_PCLK(clk), .GLOBAL_RESET(rst), .enable(en),
        .fifo_data(data[1]), .fifo_empty(empty[1]), .fifo_rd(rd[1]),
        .line_req(lreq[1]), .line_num(lnum[1]), .frame_start(fs[1]),
        .lcd_r(r[1]), .lcd_g(g[1]), .lcd_b(b[1]),
        .lcd_hsync(hsy[1]), .lcd_vsync(vsy[1]), .lcd_den(den[1]),
        .underflow(uf[1])
    );

    task automatic check(input string tag, input int i,
                         input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s[u%0d] observed=%0h expected=%0h t=%0t",
                    tag, i, obs, exp, $time);
    endtask

    function automatic int htot(input int i);
        return HS[i] + HB[i] + HA[i] + HF[i];
    endfunction

    function automatic int vtot(input int i);
        return VS[i] + VB[i] + VA[i] + VF[i];
    endfunction

    function automatic bit is_act(input int i, input int p);
        int h, v;
        h = p % htot(i);
        v = p / htot(i);
        return h >= HS[i] + HB[i] && h < HS[i] + HB[i] + HA[i] &&
               v >= VS[i] + VB[i] && v < VS[i] + VB[i] + VA[i];
    endfunction

    task automatic all_zero(input string tag, input int i);
        check({tag, "_pix"}, i, {r[i], g[i], b[i]}, 0);
        check({tag, "_hs"}, i, hsy[i], 0);
        check({tag, "_vs"}, i, vsy[i], 0);
        check({tag, "_den"}, i, den[i], 0);
        check({tag, "_fs"}, i, fs[i], 0);
        check({tag, "_lreq"}, i, lreq[i], 0);
        check({tag, "_lnum"}, i, lnum[i], 0);
        check({tag, "_uf"}, i, uf[i], 0);
    endtask

    task automatic model_edge(input int i);
        int h, v, nxt;
        bit a, e_fs, e_lr;
        logic [15:0] e_px;
        if (rst || !en) begin
            pos[i] = 0; m_uf[i] = 0; m_ln[i] = 0;
            all_zero("idle", i);
            return;
        end
        h = pos[i] % htot(i);
        v = pos[i] / htot(i);
        a = is_act(i, pos[i]);
        nxt = (v + 1) % vtot(i);
        e_fs = (pos[i] == 0);
        e_lr = (h == 0) && nxt >= VS[i] + VB[i] && nxt < VS[i] + VB[i] + VA[i];
        if (e_lr) m_ln[i] = nxt - (VS[i] + VB[i]);
        e_px = (a && !empty[i]) ? data[i] : 16'h0;
        if (e_fs) m_uf[i] = 0;
        else if (a && empty[i]) m_uf[i] = 1;
        check("pix", i, {r[i], g[i], b[i]}, e_px);
        check("hsync", i, hsy[i], h < HS[i]);
        check("vsync", i, vsy[i], v < VS[i]);
        check("den", i, den[i], a);
        check("frame_start", i, fs[i], e_fs);
        check("line_req", i, lreq[i], e_lr);
        check("line_num", i, lnum[i], m_ln[i]);
        check("underflow", i, uf[i], m_uf[i]);
        if (a && !empty[i]) ramp[i] = ramp[i] + 16'd1;
        pos[i] = (pos[i] + 1) % (htot(i) * vtot(i));
    endtask

    task automatic frame_stats();
        if (rst || !en) begin
            full = 0;
            return;
        end
        if (fs[1]) begin
            if (full) begin
                check("frame_lreq", 1, c_lr, VA[1]);
                check("frame_den", 1, c_den, HA[1] * VA[1]);
                check("frame_hs", 1, c_hs, HS[1] * vtot(1));
                check("frame_vs", 1, c_vs, VS[1] * htot(1));
            end
            full = 1;
            c_lr = 0; c_den = 0; c_hs = 0; c_vs = 0;
        end
        c_lr  += int'(lreq[1]);
        c_den += int'(den[1]);
        c_hs  += int'(hsy[1]);
        c_vs  += int'(vsy[1]);
    endtask

    task automatic cycle(input bit force_empty0);
        @(negedge clk);
        empty[0] = force_empty0;
        empty[1] = ($urandom_range(0, 39) == 0);
        for (int i = 0; i < 2; i++) data[i] = ramp[i];
        #1;
        for (int i = 0; i < 2; i++)
            check("fifo_rd", i, rd[i],
                  !rst && en && is_act(i, pos[i]) && !empty[i]);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) model_edge(i);
        frame_stats();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            pos[i] = 0; m_uf[i] = 0; m_ln[i] = 0;
            ramp[i] = 16'h0000; empty[i] = 1'b0; data[i] = 16'h0;
        end
        full = 0;
        c_lr = 0; c_den = 0; c_hs = 0; c_vs = 0;

        repeat (3) cycle(0);
        rst = 1'b0;
        repeat (3) cycle(0);
        en = 1'b1;
        repeat (700) cycle(0);

        @(negedge clk);
        #7;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            all_zero("async_rst", i);
            check("async_rst_rd", i, rd[i], 0);
            pos[i] = 0; m_uf[i] = 0; m_ln[i] = 0;
        end
        repeat (2) cycle(0);
        rst = 1'b0;

        for (int k = 0; k < 20000 && pos[0] != 13 * 525 + 100; k++)
            cycle(0);
        check("reach_v13", 0, pos[0], 13 * 525 + 100);
        repeat (3) cycle(1);
        check("uf_after_gap", 0, uf[0], 1);

        for (int k = 0; k < 60000 && pos[0] != 100 * 525 + 50; k++)
            cycle(0);
        check("reach_v100", 0, pos[0], 100 * 525 + 50);
        en = 1'b0;
        repeat (5) cycle(0);
        en = 1'b1;
        repeat (14 * 525) cycle(0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
